// File: rtl/clk_enable_gen.sv
// rtl/clk_enable_gen.sv - multi-channel fractional clock-enable generator with phase offsets and lock
module clk_enable_gen #(
  parameter int                NUM_CH      = 4,
  parameter int                ACC_W       = 24,
  parameter logic [ACC_W-1:0]  DEF_INC     = 24'h14B0C6,
  parameter int                LOCK_CYCLES = 16,
  localparam int               CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_sel,
  input  logic [ACC_W-1:0]  cfg_data,
  input  logic              sync_req,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] sq,
  output logic              locked
);

  localparam int              CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic {LOCKING = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [ACC_W-1:0]   inc_q   [NUM_CH];
  logic [ACC_W-1:0]   phase_q [NUM_CH];
  logic [ACC_W-1:0]   acc_q   [NUM_CH];
  logic [ACC_W:0]     sum     [NUM_CH];
  logic [NUM_CH-1:0]  carry_q;
  logic [NUM_CH-1:0]  ce_q;
  logic [NUM_CH-1:0]  sq_q;

  assign ce     = ce_q;
  assign sq     = sq_q;
  assign locked = (state_q == RUN);

  // Lock state and settle counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LOCKING;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: sync_req always forces a fresh settle period; otherwise count out LOCK_CYCLES.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (sync_req) begin
      state_d = LOCKING;
      cnt_d   = '0;
    end else begin
      case (state_q)
        LOCKING: begin
          if (cnt_q == CNT_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN:     state_d = RUN;
        default: state_d = LOCKING;
      endcase
    end
  end

  // Per-channel config registers; phase only takes effect at the next sync reload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        inc_q[i]   <= DEF_INC;
        phase_q[i] <= '0;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_ch == CH_W'(i)) begin
          if (cfg_sel) phase_q[i] <= cfg_data;
          else         inc_q[i]   <= cfg_data;
        end
      end
    end
  end

  // Wide add per channel; the extra bit is the wrap carry that becomes the enable.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i] = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
    end
  end

  // Accumulators and outputs: reload on sync, free-run in RUN, hold quiet while locking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
      end
      carry_q <= '0;
      ce_q    <= '0;
      sq_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sync_req) begin
          acc_q[i]   <= phase_q[i];
          carry_q[i] <= 1'b0;
          ce_q[i]    <= 1'b0;
          sq_q[i]    <= 1'b0;
        end else if (state_q == RUN) begin
          acc_q[i]   <= sum[i][ACC_W-1:0];
          carry_q[i] <= sum[i][ACC_W];
          ce_q[i]    <= carry_q[i];
          sq_q[i]    <= acc_q[i][ACC_W-1];
        end else begin
          carry_q[i] <= 1'b0;
          ce_q[i]    <= 1'b0;
          sq_q[i]    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// tb/tb_clk_enable_gen.sv - directed-vector bench for clk_enable_gen (ACC_W=16, DEF_INC=16'h4000)
module tb_clk_enable_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic        cfg_sel;
  logic [15:0] cfg_data;
  logic        sync_req;
  logic [3:0]  ce;
  logic [3:0]  sq;
  logic        locked;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0][11:0] ce_h;
  logic [3:0][11:0] sq_h;

  clk_enable_gen #(
    .NUM_CH      (4),
    .ACC_W       (16),
    .DEF_INC     (16'h4000),
    .LOCK_CYCLES (16)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_sel  (cfg_sel),
    .cfg_data (cfg_data),
    .sync_req (sync_req),
    .ce       (ce),
    .sq       (sq),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic sel, input logic [15:0] data);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_sel  = sel;
    cfg_data = data;
    step();
    cfg_we   = 1'b0;
  endtask

  task automatic relock(input string tag);
    int bad_ce;
    logic lk15;
    bad_ce = 0;
    lk15   = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (ce != 4'h0) bad_ce++;
      if (k == 15) lk15 = locked;
    end
    check_val({tag, "_locked_c15"}, {31'd0, lk15}, 32'd0);
    check_val({tag, "_locked_c16"}, {31'd0, locked}, 32'd1);
    check_val({tag, "_ce_while_locking"}, bad_ce, 0);
  endtask

  task automatic record12();
    for (int k = 0; k < 12; k++) begin
      step();
      for (int c = 0; c < 4; c++) begin
        ce_h[c][k] = ce[c];
        sq_h[c][k] = sq[c];
      end
    end
  endtask

  task automatic pulse_sync();
    sync_req = 1'b1;
    step();
    sync_req = 1'b0;
  endtask

  initial begin
    int n0, n1, n2, n3, last, bad_gap, sq_chg;
    logic sq2_prev;

    reset_n  = 1'b0;
    cfg_we   = 1'b0;
    cfg_ch   = 2'd0;
    cfg_sel  = 1'b0;
    cfg_data = 16'h0;
    sync_req = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check_val("rst_ce", {28'd0, ce}, 32'h0);
    check_val("rst_sq", {28'd0, sq}, 32'h0);
    check_val("rst_locked", {31'd0, locked}, 32'd0);

    // 1: lock after 16 cycles, ce every 4th cycle, first ce 5 cycles after lock
    reset_n = 1'b1;
    relock("t1");
    record12();
    check_val("t1_ce0_hist", ce_h[0], 12'h110);
    check_val("t1_ce3_hist", ce_h[3], 12'h110);
    check_val("t1_sq0_hist", sq_h[0], 12'hCCC);

    // 2: fractional inc 0x5555 on ch0
    cfg_write(2'd0, 1'b0, 16'h5555);
    check_val("t2_locked_kept", {31'd0, locked}, 32'd1);
    repeat (8) step();
    n0 = 0; n1 = 0; last = -1; bad_gap = 0;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (ce[1]) n1++;
      if (ce[0]) begin
        n0++;
        if (last >= 0 && (k - last < 3 || k - last > 4)) bad_gap++;
        last = k;
      end
    end
    check_val("t2_ce0_count_ok", {31'd0, (n0 == 333 || n0 == 334)}, 32'd1);
    check_val("t2_ce0_bad_gaps", bad_gap, 0);
    check_val("t2_ce1_count", n1, 250);

    // 3: phase offset on ch1, ce1 leads ce0 by two cycles
    cfg_write(2'd0, 1'b0, 16'h4000);
    cfg_write(2'd1, 1'b1, 16'h8000);
    pulse_sync();
    check_val("t3_locked_after_sync", {31'd0, locked}, 32'd0);
    relock("t3");
    record12();
    check_val("t3_ce1_hist", ce_h[1], 12'h444);
    check_val("t3_ce0_hist", ce_h[0], 12'h110);

    // 4: sync_req with a simultaneous phase write reloads the old phase
    sync_req = 1'b1;
    cfg_we   = 1'b1;
    cfg_ch   = 2'd1;
    cfg_sel  = 1'b1;
    cfg_data = 16'h0000;
    step();
    sync_req = 1'b0;
    cfg_we   = 1'b0;
    check_val("t4_ce_zero", {28'd0, ce}, 32'h0);
    check_val("t4_sq_zero", {28'd0, sq}, 32'h0);
    check_val("t4_locked_zero", {31'd0, locked}, 32'd0);
    relock("t4a");
    record12();
    check_val("t4_ce1_old_phase", ce_h[1], 12'h444);
    pulse_sync();
    relock("t4b");
    record12();
    check_val("t4_ce1_new_phase", ce_h[1], 12'h110);

    // 5: inc=0 never pulses and freezes sq; inc=0xFFFF misses one cycle in 65536
    cfg_write(2'd2, 1'b0, 16'h0000);
    cfg_write(2'd3, 1'b0, 16'hFFFF);
    repeat (4) step();
    n2 = 0; n3 = 0; sq_chg = 0;
    sq2_prev = sq[2];
    for (int k = 0; k < 65536; k++) begin
      step();
      if (ce[2]) n2++;
      if (ce[3]) n3++;
      if (sq[2] != sq2_prev) sq_chg++;
      sq2_prev = sq[2];
    end
    check_val("t5_ce2_count", n2, 0);
    check_val("t5_ce3_count", n3, 65535);
    check_val("t5_sq2_changes", sq_chg, 0);

    // 6: asynchronous reset mid-RUN clears outputs at once and restores DEF_INC
    check_val("t6_ce3_before", {31'd0, ce[3]}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_val("t6_async_ce", {28'd0, ce}, 32'h0);
    check_val("t6_async_sq", {28'd0, sq}, 32'h0);
    check_val("t6_async_locked", {31'd0, locked}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    relock("t6");
    record12();
    check_val("t6_ce0_hist", ce_h[0], 12'h110);
    check_val("t6_ce2_hist", ce_h[2], 12'h110);
    check_val("t6_ce3_hist", ce_h[3], 12'h110);
    check_val("t6_ce1_hist", ce_h[1], 12'h110);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
